vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single 16 KB video RAM between the video adapter's scanout fetches and the Z80 bus interface.
- Video fetches have absolute priority. The CPU is served with a 4-phase req/ack handshake in free cycles.
- Sits between vadapter/CPU glue and a synchronous block RAM with 1-cycle read latency.
- Runs on the 100 MHz system clock; the video adapter issues fetches at its divided rate.

Parameters:
- AW, 14, VRAM address width.
- DW, 8, data width.
- MAX_WAIT, 15, CPU pending-cycle limit before the stall_ovf flag is set.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- video_rd  in  1  one-cycle fetch strobe from the video adapter.
- video_addr  in  AW  fetch address, valid with video_rd.
- video_data  out  DW  last fetched byte.
- video_vld  out  1  one-cycle pulse when video_data updates.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  handshake acknowledge.
- cpu_rdata  out  DW  CPU read data, valid while cpu_ack.
- cpu_wait  out  1  Z80 WAIT request: cpu_req high and cpu_ack low.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after its address.
- stall_ovf  out  1  sticky: the CPU once waited ≥ MAX_WAIT cycles.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; wait counter 0. Reset mid-transfer abandons it with no RAM write after the reset cycle.
- Grant is decided per cycle, combinationally.
  - If video_rd: mem_addr = video_addr, mem_we = 0.
  - Else if FSM is ISSUE: mem_addr, mem_we and mem_wdata come from the CPU latch.
  - Else: mem_addr holds its previous value and mem_we = 0.
- Video path:
  - video_rd in cycle N drives the RAM in N.
  - mem_rdata is captured into video_data at the end of N+1, so video_data and video_vld are visible in N+2.
  - Back-to-back video_rd gives back-to-back video_vld.
  - video_data holds between updates.
- CPU FSM states: IDLE, PEND, ISSUE, RDWAIT, ACK.
  - IDLE: on cpu_req=1, latch addr/we/wdata, go to PEND. The CPU bus may change after acceptance.
  - PEND: if video_rd=0 go to ISSUE, else stay and increment the wait counter (saturating).
  - ISSUE: the RAM access happens this cycle. The FSM is only in ISSUE when video_rd was 0 in the preceding PEND cycle.
    - If video_rd also arrives in ISSUE, video wins: the FSM returns to PEND and issues nothing.
    - A write goes to ACK; a read goes to RDWAIT.
  - RDWAIT: cpu_rdata <= mem_rdata; go to ACK.
  - ACK: cpu_ack=1 and cpu_rdata is held. On cpu_req=0, deassert ack, clear the counter and go to IDLE. No new request is accepted before cpu_req has been seen low.
- Latency with no video contention:
  - Write: req seen in cycle R, ack high in R+3.
  - Read: ack high in R+4.
- stall_ovf: set when the counter reaches MAX_WAIT; cleared only by reset.
- Any RAM write is complete before its ack, so a read of the same address after a write returns the new data. A video fetch of the same address returns the new data only if issued after the ISSUE cycle.

Decomposition:
- Shared package vram_pkg:
  - FSM state encoding (3-bit enum).
  - VRAM_AW=14 and DW=8 constants.
  - The bitmap base (14'h2000) and attribute base (14'h3600) address constants, also used by vadapter.
- No sub-module needed. The single module holds the grant mux, the video capture pipe and the CPU FSM.

Test Plan:
- Video only: video_rd with addr 14'h2000, RAM preloaded 8'hA5 → mem_addr=14'h2000 the same cycle; video_data=8'hA5 with video_vld pulse 2 cycles later.
- CPU write, idle video: req with we=1, addr 14'h3600, data 8'h47 at cycle 0 → mem_we=1 in cycle 2; ack in cycle 3; ack drops the cycle after req drops; RAM[14'h3600]=8'h47.
- CPU read under contention: video_rd high for 5 cycles while a read of 14'h0010 (=8'h3C) is pending → no CPU access during video cycles; cpu_wait high throughout; ack with rdata=8'h3C after video releases; stall_ovf stays 0.
- Starvation: video_rd held high 20 cycles during a CPU request → stall_ovf=1 once 15 wait cycles are reached and it stays 1; the transfer then completes correctly.
- Handshake: req kept high after ack → no second access until req goes low then high; a new latched address is used.
- Reset mid-read, in RDWAIT → next cycle ack=0, FSM IDLE, no mem_we; video capture resumes normally.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM constants and CPU-side arbiter state encoding
package vram_pkg;
  localparam int VRAM_AW = 14;
  localparam int VRAM_DW = 8;
  localparam logic [VRAM_AW-1:0] BITMAP_BASE = 14'h2000;
  localparam logic [VRAM_AW-1:0] ATTR_BASE = 14'h3600;
  typedef enum logic [2:0] {IDLE, PEND, ISSUE, RDWAIT, ACK} state_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video fetch, CPU handshake and block RAM signals of the VRAM arbiter
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
);
  logic          video_rd;
  logic [AW-1:0] video_addr;
  logic [DW-1:0] video_data;
  logic          video_vld;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_wait;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_ovf;
  modport slave (
    input  video_rd, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output video_data, video_vld, cpu_ack, cpu_rdata, cpu_wait, mem_addr, mem_we, mem_wdata, stall_ovf
  );
  modport master (
    output video_rd, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  video_data, video_vld, cpu_ack, cpu_rdata, cpu_wait, mem_addr, mem_we, mem_wdata, stall_ovf
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM between priority video fetches and a req/ack CPU port
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW       = VRAM_AW,
  parameter int DW       = VRAM_DW,
  parameter int MAX_WAIT = 15
) (
  input  logic           clock,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic          we_q, we_d, vrd_q, vrd_d, vvld_q, vvld_d, ovf_q, ovf_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d, vdata_q, vdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cpu_issue;
  // state register and all pipeline/latch flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      vrd_q      <= 1'b0;
      vvld_q     <= 1'b0;
      vdata_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      vrd_q      <= vrd_d;
      vvld_q     <= vvld_d;
      vdata_q    <= vdata_d;
      mem_addr_q <= mem_addr_d;
    end
  end
  // next state: CPU handshake FSM, wait counter and video capture pipe
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q | (cnt_q == CW'(MAX_WAIT));
    vrd_d      = bus.video_rd;
    vvld_d     = vrd_q;
    vdata_d    = vrd_q ? bus.mem_rdata : vdata_q;
    mem_addr_d = bus.mem_addr;
    case (state_q)
      IDLE: if (bus.cpu_req) begin
        addr_d  = bus.cpu_addr;
        we_d    = bus.cpu_we;
        wdata_d = bus.cpu_wdata;
        state_d = PEND;
      end
      PEND: if (!bus.video_rd) state_d = ISSUE;
        else if (cnt_q != CW'(MAX_WAIT)) cnt_d = cnt_q + 1'b1;
      ISSUE: state_d = bus.video_rd ? PEND : we_q ? ACK : RDWAIT;
      RDWAIT: begin
        rdata_d = bus.mem_rdata;
        state_d = ACK;
      end
      ACK: if (!bus.cpu_req) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs: per-cycle grant mux, video wins over an ISSUE in the same cycle
  always_comb begin
    cpu_issue      = state_q == ISSUE && !bus.video_rd;
    bus.mem_addr   = bus.video_rd ? bus.video_addr : cpu_issue ? addr_q : mem_addr_q;
    bus.mem_we     = cpu_issue && we_q && !reset;
    bus.mem_wdata  = wdata_q;
    bus.cpu_ack    = state_q == ACK;
    bus.cpu_wait   = bus.cpu_req && state_q != ACK;
    bus.cpu_rdata  = rdata_q;
    bus.video_data = vdata_q;
    bus.video_vld  = vvld_q;
    bus.stall_ovf  = ovf_q;
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for the VRAM arbiter with a 1-cycle block RAM model
module tb_vram_arbiter;
  typedef struct {logic [7:0] d; int c;} vexp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, n_chk = 0, n_pass = 0;
  logic [7:0] ram [16384];
  logic [7:0] model [16384];
  vexp_t vq[$];
  logic [7:0] cq[$];
  vram_arbiter_if bus ();
  vram_arbiter dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  task automatic sm();
    @(negedge clk);
  endtask
  task automatic vid(input logic on, input logic [13:0] a);
    bus.video_rd = on;
    bus.video_addr = a;
    if (on) vq.push_back('{model[a], cyc + 2});
  endtask
  task automatic wait_ack(input string tag, input logic rd);
    for (int i = 0; i < 40 && !bus.cpu_ack; i++) begin
      nx();
      sm();
    end
    chk({tag, "_ack"}, bus.cpu_ack, 1);
    if (rd) begin
      if (cq.size() == 0) chk({tag, "_cq"}, 0, 1);
      else chk({tag, "_rdata"}, bus.cpu_rdata, cq.pop_front());
    end
  endtask
  task automatic cpu_xfer(input string tag, input logic we, input logic [13:0] a, input logic [7:0] d);
    nx();
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    if (!we) cq.push_back(model[a]);
    sm();
    nx();
    bus.cpu_we = ~we; bus.cpu_addr = ~a; bus.cpu_wdata = ~d;
    sm();
    wait_ack(tag, !we);
    if (we) model[a] = d;
    nx();
    bus.cpu_req = 0;
    sm();
    nx();
    sm();
    chk({tag, "_ackdrop"}, bus.cpu_ack, 0);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.video_vld) begin
      if (vq.size() == 0) chk("vid_spurious", 1, 0);
      else begin
        chk("vid_data", bus.video_data, vq[0].d);
        chk("vid_cycle", cyc, vq[0].c);
        void'(vq.pop_front());
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    bus.video_rd = 0; bus.video_addr = 0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0;
    for (int i = 0; i < 16384; i++) begin
      model[i] = 8'(i * 7 + 3);
      ram[i] = model[i];
    end
    model[14'h2000] = 8'hA5; ram[14'h2000] = 8'hA5;
    model[14'h0010] = 8'h3C; ram[14'h0010] = 8'h3C;
    repeat (3) nx();
    rst = 0;
    sm();
    chk("rst_vvld", bus.video_vld, 0);
    chk("rst_vdata", bus.video_data, 0);
    chk("rst_ack", bus.cpu_ack, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_wait", bus.cpu_wait, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_ovf", bus.stall_ovf, 0);
    // video only
    nx(); vid(1, 14'h2000); sm();
    chk("v_addr", bus.mem_addr, 14'h2000);
    chk("v_we", bus.mem_we, 0);
    nx(); vid(0, 0); sm();
    chk("v_hold_addr", bus.mem_addr, 14'h2000);
    chk("v_vld_early", bus.video_vld, 0);
    nx(); sm();
    chk("v_data", bus.video_data, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      nx(); vid(1, 14'(16 + i)); sm();
    end
    nx(); vid(0, 0); sm();
    repeat (3) begin nx(); sm(); end
    chk("v_data_hold", bus.video_data, model[14'h0012]);
    chk("v_vld_idle", bus.video_vld, 0);
    // CPU write, idle video
    nx();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'h3600; bus.cpu_wdata = 8'h47;
    sm();
    chk("w_wait0", bus.cpu_wait, 1);
    chk("w_we0", bus.mem_we, 0);
    nx(); bus.cpu_addr = 14'h1234; bus.cpu_wdata = 8'h00; sm();
    chk("w_we1", bus.mem_we, 0);
    nx(); sm();
    chk("w_we2", bus.mem_we, 1);
    chk("w_addr2", bus.mem_addr, 14'h3600);
    chk("w_wdata2", bus.mem_wdata, 8'h47);
    chk("w_ack2", bus.cpu_ack, 0);
    nx(); sm();
    chk("w_ack3", bus.cpu_ack, 1);
    chk("w_wait3", bus.cpu_wait, 0);
    nx(); bus.cpu_req = 0; sm();
    chk("w_ack4", bus.cpu_ack, 1);
    nx(); sm();
    chk("w_ack5", bus.cpu_ack, 0);
    chk("w_ram", ram[14'h3600], 8'h47);
    model[14'h3600] = 8'h47;
    // CPU read under video contention
    nx();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'h0010;
    cq.push_back(model[14'h0010]);
    sm();
    for (int i = 0; i < 5; i++) begin
      nx(); vid(1, 14'(14'h2100 + i)); sm();
      chk("c_wait", bus.cpu_wait, 1);
      chk("c_addr", bus.mem_addr, 14'(14'h2100 + i));
      chk("c_we", bus.mem_we, 0);
    end
    nx(); vid(0, 0); sm();
    chk("c_wait_after", bus.cpu_wait, 1);
    wait_ack("c", 1);
    chk("c_ovf", bus.stall_ovf, 0);
    nx(); bus.cpu_req = 0; sm();
    nx(); sm();
    // starvation
    nx();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'h3601;
    cq.push_back(model[14'h3601]);
    sm();
    for (int i = 1; i <= 20; i++) begin
      nx(); vid(1, 14'(14'h2200 + i)); sm();
      chk("s_wait", bus.cpu_wait, 1);
      if (i == 10) chk("s_ovf_early", bus.stall_ovf, 0);
      if (i == 18) chk("s_ovf_set", bus.stall_ovf, 1);
    end
    nx(); vid(0, 0); sm();
    wait_ack("s", 1);
    chk("s_ovf_ack", bus.stall_ovf, 1);
    nx(); bus.cpu_req = 0; sm();
    nx(); sm();
    chk("s_ovf_sticky", bus.stall_ovf, 1);
    // handshake: req held after ack
    nx();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'h0020;
    cq.push_back(model[14'h0020]);
    sm();
    wait_ack("h", 1);
    for (int i = 0; i < 4; i++) begin
      nx(); bus.cpu_addr = 14'h3600; sm();
      chk("h_ack_held", bus.cpu_ack, 1);
      chk("h_no_we", bus.mem_we, 0);
      chk("h_rdata_hold", bus.cpu_rdata, model[14'h0020]);
    end
    nx(); bus.cpu_req = 0; sm();
    nx(); sm();
    chk("h_ack_low", bus.cpu_ack, 0);
    cpu_xfer("h2", 0, 14'h3600, 8'h00);
    // reset while in RDWAIT
    nx();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'h0030;
    sm();
    nx(); sm();
    nx(); sm();
    nx(); rst = 1; bus.cpu_req = 0; sm();
    nx(); rst = 0; sm();
    chk("r_ack", bus.cpu_ack, 0);
    chk("r_we", bus.mem_we, 0);
    chk("r_wait", bus.cpu_wait, 0);
    chk("r_rdata", bus.cpu_rdata, 0);
    chk("r_ovf", bus.stall_ovf, 0);
    for (int i = 0; i < 3; i++) begin
      nx(); sm();
      chk("r_idle_we", bus.mem_we, 0);
    end
    nx(); vid(1, 14'h2000); sm();
    nx(); vid(0, 0); sm();
    nx(); sm();
    cpu_xfer("r2", 1, 14'h0040, 8'h99);
    nx(); vid(1, 14'h0040); sm();
    nx(); vid(0, 0); sm();
    repeat (3) begin nx(); sm(); end
    chk("end_vq_empty", vq.size(), 0);
    chk("end_cq_empty", cq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
